// File: rtl/servo_pwm_capture.sv
`default_nettype none
// servo_pwm_capture: measures servo PWM high time and decodes it to an 8-bit position,
// flagging rejected pulses and loss of signal. Optional macro SERVO_PWM_CAPTURE_AVG_EN
// adds a 4-sample moving average on pos_out (one extra cycle of latency).
module servo_pwm_capture #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int MIN_PULSE_US = 600,
    parameter int MAX_PULSE_US = 2400,
    parameter int TIMEOUT_MS   = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pwm_in,
    output logic [7:0] pos_out,
    output logic       pos_valid,
    output logic       range_err,
    output logic       signal_lost
);
    localparam int MIN_CYC     = (CLK_FREQ_HZ / 1_000_000) * MIN_PULSE_US;
    localparam int MAX_CYC     = (CLK_FREQ_HZ / 1_000_000) * MAX_PULSE_US;
    localparam int SPAN        = MAX_CYC - MIN_CYC;
    localparam int GLITCH_CYC  = MIN_CYC / 2;
    localparam int STUCK_CYC   = 2 * MAX_CYC;
    localparam int TIMEOUT_CYC = (CLK_FREQ_HZ / 1000) * TIMEOUT_MS;
    localparam int CW          = $clog2(STUCK_CYC + 2);
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] MIN_W    = CW'(MIN_CYC);
    localparam logic [CW-1:0] MAX_W    = CW'(MAX_CYC);
    localparam logic [CW-1:0] GLITCH_W = CW'(GLITCH_CYC);
    localparam logic [CW-1:0] STUCK_W  = CW'(STUCK_CYC);
    localparam logic [TW-1:0] TMO_W    = TW'(TIMEOUT_CYC);
    localparam logic [39:0]   SPAN_L   = 40'(SPAN);

    typedef enum logic [1:0] {WAIT_LOW = 2'd0, ARMED = 2'd1, HIGH = 2'd2} state_t;

    logic          sync1, s, s_d;
    logic [1:0]    settle;
    logic          rise, fall;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [TW-1:0] tcnt;
    logic          take, reject;
    logic [39:0]   prod;
    logic [7:0]    dec;

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // settle marks when s holds a real sample rather than the reset value, so a
    // pulse already high at reset release is not mistaken for a low line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
            settle <= 2'b00;
            state  <= WAIT_LOW;
            cnt    <= '0;
        end else begin
            sync1  <= pwm_in;
            s      <= sync1;
            s_d    <= s;
            settle <= {settle[0], 1'b1};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        reject    = 1'b0;
        case (state)
            WAIT_LOW: if (settle[1] && !s) state_nxt = ARMED;
            ARMED: begin
                if (rise) begin
                    cnt_nxt   = CW'(1);
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (cnt > STUCK_W) begin
                    reject    = 1'b1;
                    state_nxt = WAIT_LOW;
                end else if (fall) begin
                    state_nxt = ARMED;
                    if (cnt < GLITCH_W) reject = 1'b1;
                    else                take   = 1'b1;
                end else if (s) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = WAIT_LOW;
        endcase
    end

    always_comb begin
        prod = 40'(cnt - MIN_W) * 40'd255;
        if (cnt <= MIN_W)      dec = 8'd0;
        else if (cnt >= MAX_W) dec = 8'd255;
        else                   dec = 8'(prod / SPAN_L);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt      <= '0;
            range_err <= 1'b0;
        end else begin
            range_err <= reject;
            if (rise)               tcnt <= '0;
            else if (tcnt != TMO_W) tcnt <= tcnt + TW'(1);
        end
    end

    // A rise in the trip cycle wins, so the level is masked by rise directly.
    assign signal_lost = (tcnt == TMO_W) && !rise;

`ifdef SERVO_PWM_CAPTURE_AVG_EN
    logic [7:0] raw_pos;
    logic       raw_val;
    logic [7:0] hist [4];
    logic       primed;
    logic [9:0] sum_nxt;

    assign sum_nxt = 10'(raw_pos) + 10'(hist[0]) + 10'(hist[1]) + 10'(hist[2]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_pos   <= 8'd127;
            raw_val   <= 1'b0;
            primed    <= 1'b0;
            pos_out   <= 8'd127;
            pos_valid <= 1'b0;
            for (int i = 0; i < 4; i++) hist[i] <= 8'd0;
        end else begin
            raw_val   <= take;
            if (take) raw_pos <= dec;
            pos_valid <= raw_val;
            if (raw_val) begin
                if (!primed) begin
                    for (int i = 0; i < 4; i++) hist[i] <= raw_pos;
                    pos_out <= raw_pos;
                    primed  <= 1'b1;
                end else begin
                    hist[0] <= raw_pos;
                    hist[1] <= hist[0];
                    hist[2] <= hist[1];
                    hist[3] <= hist[2];
                    pos_out <= 8'(sum_nxt >> 2);
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_out   <= 8'd127;
            pos_valid <= 1'b0;
        end else begin
            pos_valid <= take;
            if (take) pos_out <= dec;
        end
    end
`endif

endmodule
`default_nettype wire
